// File: rtl/gb_vga_scaler.sv
// Game Boy line buffers -> scaled, centred VGA raster (optional scanline dimming via SCANLINE_EN).
// Latency: 2 cycles from raster counters to pins, syncs aligned; lineAck 1 cycle after acceptance, no backpressure.
module gb_vga_scaler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SRC_W    = 160,
    parameter int SRC_H    = 144,
    parameter int SCALE    = 2,
    parameter int X_OFF    = 160,
    parameter int Y_OFF    = 96
) (
    input  logic             pixelClk,
    input  logic             reset,
    input  logic [7:0]       LY,
    input  logic [SRC_W-1:0] LineBuffer0,
    input  logic [SRC_W-1:0] LineBuffer1,
    input  logic             updateBufferSignal,
    output logic             lineAck,
    output logic             HSync,
    output logic             VSync,
    output logic [3:0]       R,
    output logic [3:0]       G,
    output logic [3:0]       B,
    output logic             frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW      = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] X_BEG   = HW'(X_OFF);
    localparam logic [HW-1:0] X_END   = HW'(X_OFF + SRC_W * SCALE);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] Y_BEG   = VW'(Y_OFF);
    localparam logic [VW-1:0] Y_END   = VW'(Y_OFF + SRC_H * SCALE);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [8:0]    LY_LIM  = 9'(SRC_H);

    // Raster and source-coordinate counters
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic [SW-1:0] subx_q, subx_d;
    logic [SW-1:0] suby_q, suby_d;

    logic h_win, v_win, in_win, active, line_end;

    always_comb begin
        line_end = (h_q == H_LAST);
        h_win    = (h_q >= X_BEG) && (h_q < X_END);
        v_win    = (v_q >= Y_BEG) && (v_q < Y_END);
        active   = (h_q < H_ACT) && (v_q < V_ACT);
        in_win   = h_win && v_win && active;

        h_d    = line_end ? '0 : h_q + 1'b1;
        v_d    = v_q;
        sx_d   = '0;
        subx_d = '0;
        sy_d   = sy_q;
        suby_d = suby_q;

        if (line_end) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end

        if (h_win) begin
            if (subx_q == SUB_LAST) begin
                subx_d = '0;
                sx_d   = sx_q + 1'b1;
            end else begin
                subx_d = subx_q + 1'b1;
                sx_d   = sx_q;
            end
        end

        // Vertical source index steps once per output line, only while inside the image rows.
        if (line_end) begin
            if (v_win) begin
                if (suby_q == SUB_LAST) begin
                    suby_d = '0;
                    sy_d   = sy_q + 1'b1;
                end else begin
                    suby_d = suby_q + 1'b1;
                end
            end else begin
                suby_d = '0;
                sy_d   = '0;
            end
        end
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            h_q    <= '0;
            v_q    <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            subx_q <= '0;
            suby_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            subx_q <= subx_d;
            suby_q <= suby_d;
        end
    end

    // Line capture into the frame store
    logic [SRC_W-1:0] plane0_mem [SRC_H];
    logic [SRC_W-1:0] plane1_mem [SRC_H];
    logic [7:0]       last_ly_q;
    logic             line_ack_q;
    logic             accept;
    logic [YW-1:0]    wr_y;

    always_comb begin
        accept = updateBufferSignal && (LY != last_ly_q) && ({1'b0, LY} < LY_LIM);
        wr_y   = LY[YW-1:0];
    end

    always_ff @(posedge pixelClk) begin
        if (accept) begin
            plane0_mem[wr_y] <= LineBuffer0;
            plane1_mem[wr_y] <= LineBuffer1;
        end
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            last_ly_q  <= 8'hFF;
            line_ack_q <= 1'b0;
        end else begin
            line_ack_q <= accept;
            if (accept) begin
                last_ly_q <= LY;
            end
        end
    end

    // Stage 1: frame-store read plus delayed sync/window flags
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    logic          hs_raw, vs_raw, fs_raw, dim_raw;

    always_comb begin
        rd_x   = in_win ? sx_q : '0;
        rd_y   = in_win ? sy_q : '0;
        hs_raw = !((h_q >= HS_BEG) && (h_q <= HS_END));
        vs_raw = !((v_q >= VS_BEG) && (v_q <= VS_END));
        fs_raw = (h_q == '0) && (v_q == '0);
`ifdef SCANLINE_EN
        dim_raw = (SCALE >= 2) && (suby_q == SUB_LAST);
`else
        dim_raw = 1'b0;
`endif
    end

    logic [1:0] s1_shade_q;
    logic       s1_win_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_dim_q;

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            s1_shade_q <= 2'b00;
            s1_win_q   <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            s1_fs_q    <= 1'b0;
            s1_dim_q   <= 1'b0;
        end else begin
            s1_shade_q <= {plane1_mem[rd_y][rd_x], plane0_mem[rd_y][rd_x]};
            s1_win_q   <= in_win;
            s1_hs_q    <= hs_raw;
            s1_vs_q    <= vs_raw;
            s1_fs_q    <= fs_raw;
            s1_dim_q   <= dim_raw;
        end
    end

    // Stage 2: palette lookup and output registers
    logic [11:0] rgb_d, rgb_q;
    logic        hsync_q, vsync_q, frame_start_q;

    always_comb begin
        rgb_d = 12'h000;
        case (s1_shade_q)
            2'b00:   rgb_d = 12'hDFC;
            2'b01:   rgb_d = 12'h8B7;
            2'b10:   rgb_d = 12'h365;
            default: rgb_d = 12'h112;
        endcase
        if (s1_dim_q) begin
            rgb_d = {1'b0, rgb_d[11:9], 1'b0, rgb_d[7:5], 1'b0, rgb_d[3:1]};
        end
        if (!s1_win_q) begin
            rgb_d = 12'h000;
        end
    end

    always_ff @(posedge pixelClk or posedge reset) begin
        if (reset) begin
            rgb_q         <= 12'h000;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            rgb_q         <= rgb_d;
            hsync_q       <= s1_hs_q;
            vsync_q       <= s1_vs_q;
            frame_start_q <= s1_fs_q;
        end
    end

    assign R          = rgb_q[11:8];
    assign G          = rgb_q[7:4];
    assign B          = rgb_q[3:0];
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign frameStart = frame_start_q;
    assign lineAck    = line_ack_q;

endmodule

// File: tb/tb_gb_vga_scaler.sv
// Bench for gb_vga_scaler on a reduced raster (80x46 total, 16x12 source, 2x scale, offset 16/8).
module tb_gb_vga_scaler;

    localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int SRC_W = 16, SRC_H = 12, SCALE = 2, X_OFF = 16, Y_OFF = 8;
    localparam int H_TOTAL = 80;
    localparam int V_TOTAL = 46;
    localparam int FRAME   = 3680;
    localparam int HS_LAT  = 70;    // first HSync low: column 68 plus 2 pipeline cycles
`ifdef SCANLINE_EN
    localparam bit SL = 1'b1;
`else
    localparam bit SL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ly  = 8'd0;
    logic [15:0] lb0 = 16'h0;
    logic [15:0] lb1 = 16'h0;
    logic        upd = 1'b0;
    logic        ack, hs, vs, fs;
    logic [3:0]  r, g, b;

    gb_vga_scaler #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .X_OFF(X_OFF), .Y_OFF(Y_OFF)
    ) dut (
        .pixelClk(clk), .reset(rst), .LY(ly), .LineBuffer0(lb0), .LineBuffer1(lb1),
        .updateBufferSignal(upd), .lineAck(ack), .HSync(hs), .VSync(vs),
        .R(r), .G(g), .B(b), .frameStart(fs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        string       name;
    } pexp_t;

    pexp_t px_q[$];
    int    ack_q[$];

    function automatic logic [11:0] pal(input logic [1:0] s, input bit dimrow);
        logic [11:0] c;
        logic [11:0] d;
        case (s)
            2'd0:    begin c = 12'hDFC; d = 12'h676; end
            2'd1:    begin c = 12'h8B7; d = 12'h453; end
            2'd2:    begin c = 12'h365; d = 12'h132; end
            default: begin c = 12'h112; d = 12'h001; end
        endcase
        return (dimrow && SL) ? d : c;
    endfunction

    task automatic pe(input int x, input int y, input logic [11:0] rgb, input string name);
        pexp_t e;
        e.x = x; e.y = y; e.rgb = rgb; e.hs = 1'b1; e.vs = 1'b1; e.name = name;
        px_q.push_back(e);
    endtask

    task automatic ps(input int x, input int y, input logic h, input logic v, input string name);
        pexp_t e;
        e.x = x; e.y = y; e.rgb = 12'h000; e.hs = h; e.vs = v; e.name = name;
        px_q.push_back(e);
    endtask

    // Output position tracker and pixel scoreboard
    int    px = 0, py = 0;
    bit    pos_ok = 1'b0;
    pexp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            pos_ok = 1'b0;
        end else begin
            if (fs) begin
                px = 0; py = 0; pos_ok = 1'b1;
            end else if (pos_ok) begin
                px++;
                if (px == H_TOTAL) begin
                    px = 0; py++;
                    if (py == V_TOTAL) py = 0;
                end
            end
            if (pos_ok && px_q.size() > 0 && px_q[0].x == px && px_q[0].y == py) begin
                cur = px_q.pop_front();
                chk({cur.name, "_rgb"}, int'({r, g, b}), int'(cur.rgb));
                chk({cur.name, "_hsync"}, int'(hs), int'(cur.hs));
                chk({cur.name, "_vsync"}, int'(vs), int'(cur.vs));
            end
        end
    end

    // lineAck scoreboard
    always @(negedge clk) begin
        if (!rst && ack) begin
            if (ack_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL lineAck_spurious: pulse at cycle %0d, none expected", cyc);
            end else begin
                chk("lineAck_cycle", cyc, ack_q.pop_front());
            end
        end
    end

    // Sync pulse widths and frame period
    int hs_run = 0, vs_run = 0, last_fs = -1;
    always @(negedge clk) begin
        if (rst) begin
            hs_run = 0; vs_run = 0; last_fs = -1;
        end else begin
            if (!hs) hs_run++;
            else if (hs_run > 0) begin chk("hsync_width", hs_run, H_SYNC); hs_run = 0; end
            if (!vs) vs_run++;
            else if (vs_run > 0) begin chk("vsync_width", vs_run, V_SYNC * H_TOTAL); vs_run = 0; end
            if (fs) begin
                if (last_fs >= 0) chk("frame_period", cyc - last_fs, FRAME);
                last_fs = cyc;
            end
        end
    end

    task automatic reset_vals(input string tag);
        chk({tag, "_rst_hsync"}, int'(hs), 1);
        chk({tag, "_rst_vsync"}, int'(vs), 1);
        chk({tag, "_rst_rgb"}, int'({r, g, b}), 0);
        chk({tag, "_rst_fs"}, int'(fs), 0);
        chk({tag, "_rst_ack"}, int'(ack), 0);
    endtask

    task automatic startup(input string tag);
        int fs_at = -1;
        int hs_at = -1;
        for (int n = 1; n <= 200 && (fs_at < 0 || hs_at < 0); n++) begin
            @(negedge clk);
            if (fs && fs_at < 0) fs_at = n;
            if (!hs && hs_at < 0) hs_at = n;
        end
        chk({tag, "_framestart_latency"}, fs_at, 2);
        chk({tag, "_hsync_first_low"}, hs_at, HS_LAT);
    endtask

    task automatic ldrive(input logic [7:0] l, input logic [15:0] p0, input logic [15:0] p1,
                          input bit exp_ack);
        ly = l; lb0 = p0; lb1 = p1; upd = 1'b1;
        if (exp_ack) ack_q.push_back(cyc + 1);
        @(negedge clk);
    endtask

    task automatic wait_sb(input string tag);
        pexp_t e;
        for (int i = 0; i < 3 * FRAME && px_q.size() != 0; i++) @(negedge clk);
        while (px_q.size() != 0) begin
            e = px_q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s_%s: pixel (%0d,%0d) never observed within the cycle budget", tag, e.name, e.x, e.y);
        end
    endtask

    initial begin
        bool_wait: begin end
        repeat (3) @(negedge clk);
        reset_vals("por");
        rst = 1'b0;
        startup("por");

        // Line 0: all shade 01 -> rows 8,9, cols 16..47
        ldrive(8'd0, 16'hFFFF, 16'h0000, 1'b1);
        upd = 1'b0;
        repeat (4) @(negedge clk);
        pe(15, 8, 12'h000, "l0_left_edge");
        pe(16, 8, pal(2'd1, 1'b0), "l0_first_col");
        pe(47, 8, pal(2'd1, 1'b0), "l0_last_col");
        pe(48, 8, 12'h000, "l0_right_edge");
        pe(16, 9, pal(2'd1, 1'b1), "l0_row2");
        ps(67, 9, 1'b1, 1'b1, "hs_before");
        ps(68, 9, 1'b0, 1'b1, "hs_start");
        ps(75, 9, 1'b0, 1'b1, "hs_end");
        ps(76, 9, 1'b1, 1'b1, "hs_after");
        ps(0, 41, 1'b1, 1'b1, "vs_before");
        ps(0, 42, 1'b1, 1'b0, "vs_start");
        ps(79, 43, 1'b1, 1'b0, "vs_end");
        ps(0, 44, 1'b1, 1'b1, "vs_after");
        wait_sb("A");

        // Accept filter, back-to-back acceptance and pattern lines
        ldrive(8'd5, 16'h00FF, 16'hFF00, 1'b1);
        ldrive(8'd5, 16'h00FF, 16'hFF00, 1'b0);
        ldrive(8'd200, 16'h1234, 16'h5678, 1'b0);
        ldrive(8'd5, 16'h00FF, 16'hFF00, 1'b0);
        ldrive(8'd6, 16'h0000, 16'h0000, 1'b1);
        ldrive(8'd1, 16'h0000, 16'h0000, 1'b1);
        ldrive(8'd2, 16'h0000, 16'h0000, 1'b1);
        ldrive(8'd3, 16'hAAAA, 16'hAAAA, 1'b1);
        ldrive(8'd11, 16'hFFFF, 16'hFFFF, 1'b1);
        upd = 1'b0;
        repeat (4) @(negedge clk);
        chk("ack_pending_B", ack_q.size(), 0);
        pe(16, 14, pal(2'd0, 1'b0), "l3_px0a");
        pe(17, 14, pal(2'd0, 1'b0), "l3_px0b");
        pe(18, 14, pal(2'd3, 1'b0), "l3_px1a");
        pe(19, 14, pal(2'd3, 1'b0), "l3_px1b");
        pe(16, 15, pal(2'd0, 1'b1), "l3_row2_px0");
        pe(18, 15, pal(2'd3, 1'b1), "l3_row2_px1");
        pe(30, 18, pal(2'd1, 1'b0), "l5_px7");
        pe(32, 18, pal(2'd2, 1'b0), "l5_px8");
        pe(47, 18, pal(2'd2, 1'b0), "l5_px15");
        pe(48, 18, 12'h000, "l5_right_edge");
        pe(32, 19, pal(2'd2, 1'b1), "l5_row2_px8");
        pe(16, 30, pal(2'd3, 1'b0), "l11_row1");
        pe(16, 31, pal(2'd3, 1'b1), "l11_row2");
        pe(16, 32, 12'h000, "below_window");
        wait_sb("B");

        // Reset mid-frame for 3 cycles
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 2 * FRAME && !hit; i++) begin
                @(negedge clk);
                if (pos_ok && px == 40 && py == 30) hit = 1'b1;
            end
            chk("mid_reset_position_reached", int'(hit), 1);
        end
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            reset_vals("mid");
        end
        rst = 1'b0;
        startup("mid");

        // lastLY cleared by reset, so LY=5 is accepted again; frame store retained
        ldrive(8'd5, 16'h00FF, 16'hFF00, 1'b1);
        upd = 1'b0;
        repeat (4) @(negedge clk);
        chk("ack_pending_C", ack_q.size(), 0);
        pe(16, 8, pal(2'd1, 1'b0), "post_rst_l0");
        pe(16, 14, pal(2'd0, 1'b0), "post_rst_l3");
        pe(30, 18, pal(2'd1, 1'b0), "post_rst_l5");
        wait_sb("C");

        while (ack_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL lineAck_missing: expected pulse at cycle %0d", ack_q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
